// File: rtl/bin2bcd_seq_if.sv
`timescale 1ns/1ps
// Handshake bundle between the counter side and the BCD converter.
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 12,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out
  );
endinterface

// File: rtl/bin2bcd_seq.sv
`timescale 1ns/1ps
// Iterative double-dabble binary-to-BCD converter, one bit per clock; done pulses WIDTH+1 cycles after start.
// No backpressure: start is accepted only when idle and ignored (not queued) while busy; bcd_out holds between conversions.
module bin2bcd_seq #(
  parameter int WIDTH  = 12,
  parameter int DIGITS = 4
) (
  input  logic          clk,
  input  logic          rst,
  bin2bcd_seq_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]          state;
  logic [WIDTH-1:0]    shift_reg;
  logic [BW-1:0]       scratch;
  logic [CW-1:0]       cnt;
  logic [BW-1:0]       bcd_q;
  logic                done_q;

  logic [BW-1:0]       corrected;
  logic [BW+WIDTH-1:0] shifted;

  // Add-3 is applied per nibble from pre-shift values; no carry crosses nibbles.
  always_comb begin
    corrected = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        corrected[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  assign shifted = {corrected, shift_reg} << 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      scratch   <= '0;
      cnt       <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            shift_reg <= bus.bin_in;
            scratch   <= '0;
            cnt       <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          scratch   <= shifted[BW+WIDTH-1:WIDTH];
          shift_reg <= shifted[WIDTH-1:0];
          cnt       <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            bcd_q  <= shifted[BW+WIDTH-1:WIDTH];
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = (state == SHIFT);
  assign bus.done    = done_q;
  assign bus.bcd_out = bcd_q;

endmodule
